// File: rtl/array_div_pkg.sv
// Shared types and helpers for the sequential array divider.
package array_div_pkg;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} div_state_t;

  localparam int DEF_N    = 6;
  localparam int DEF_W    = 36;
  localparam int DEF_FRAC = 16;

  // Largest representable value as a w-bit pattern (w <= 64).
  function automatic logic [63:0] sat_max(input int w, input bit s);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < w - int'(s)) r[i] = 1'b1;
    end
    return r;
  endfunction

  // Smallest representable value as a w-bit pattern: 100..0 when signed, 0 otherwise.
  function automatic logic [63:0] sat_min(input int w, input bit s);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      if (s && (i == w - 1)) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/div_iter_lane.sv
// One radix-2 restoring divider lane: iteration step, sign fix-up and saturation.
module div_iter_lane
  import array_div_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int FRAC   = DEF_FRAC,
  parameter bit SIGNED = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         step,
  input  logic         fix,
  input  logic         div0,
  input  logic [W-1:0] dividend,
  input  logic         divisor_neg,
  input  logic [W-1:0] divisor_mag,
  output logic [W-1:0] quotient,
  output logic         ovf
);

  localparam int QB = W + FRAC;
  localparam logic [W-1:0]  MAXV    = W'(sat_max(W, SIGNED));
  localparam logic [W-1:0]  MINV    = W'(sat_min(W, SIGNED));
  localparam logic [QB-1:0] MAX_EXT = QB'(MAXV);
  localparam logic [QB-1:0] MIN_EXT = QB'(MINV);

  logic [W-1:0]  rem;
  logic [QB-1:0] acc;
  logic          neg;

  logic          dvd_neg;
  logic [W-1:0]  dvd_mag;
  logic [W:0]    rem_sh;
  logic          ge;
  logic [W-1:0]  diff;
  logic          too_big;
  logic [W-1:0]  fix_q;
  logic          fix_ovf;

  // The W-bit unsigned magnitude of -2^(W-1) is exactly 2^(W-1), so no extra bit is kept.
  assign dvd_neg = SIGNED && dividend[W-1];
  assign dvd_mag = dvd_neg ? (~dividend + 1'b1) : dividend;

  assign rem_sh = {rem, acc[QB-1]};
  assign ge     = rem_sh >= {1'b0, divisor_mag};
  assign diff   = rem_sh[W-1:0] - divisor_mag;

  // acc holds the numerator on load and the quotient magnitude once iteration is over.
  assign too_big = neg ? (acc > MIN_EXT) : (acc > MAX_EXT);

  always_comb begin
    fix_q   = '0;
    fix_ovf = 1'b0;
    if (div0) begin
      if (acc != '0) fix_q = neg ? MINV : MAXV;
    end else if (too_big) begin
      fix_q   = neg ? MINV : MAXV;
      fix_ovf = 1'b1;
    end else begin
      fix_q = neg ? (~acc[W-1:0] + 1'b1) : acc[W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem      <= '0;
      acc      <= '0;
      neg      <= 1'b0;
      quotient <= '0;
      ovf      <= 1'b0;
    end else if (load) begin
      rem <= '0;
      acc <= {dvd_mag, {FRAC{1'b0}}};
      neg <= dvd_neg ^ divisor_neg;
    end else if (step) begin
      rem <= ge ? diff : rem_sh[W-1:0];
      acc <= {acc[QB-2:0], ge};
    end else if (fix) begin
      quotient <= fix_q;
      ovf      <= fix_ovf;
    end
  end

endmodule

// File: rtl/array_div_seq.sv
// N-lane sequential fixed-point divider sharing one divisor, with valid/ready on both sides.
module array_div_seq
  import array_div_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int W      = DEF_W,
  parameter int FRAC   = DEF_FRAC,
  parameter bit SIGNED = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        divisor,
  input  logic [N-1:0][W-1:0] dividends,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N-1:0][W-1:0] quotients,
  output logic                div0,
  output logic [N-1:0]        ovf
);

  localparam int QB = W + FRAC;
  localparam int CW = (QB > 1) ? $clog2(QB) : 1;

  div_state_t   state;
  logic [CW-1:0] cnt;
  logic [W-1:0] dvs_mag;
  logic         div0_job;

  logic         accept;
  logic         dvs_neg_in;
  logic [W-1:0] dvs_mag_in;
  logic         dvs_zero;

  assign in_ready   = reset_n & ((state == S_IDLE) | ((state == S_DONE) & out_ready));
  assign accept     = in_valid & in_ready;
  assign dvs_neg_in = SIGNED && divisor[W-1];
  assign dvs_mag_in = dvs_neg_in ? (~divisor + 1'b1) : divisor;
  assign dvs_zero   = (divisor == '0);

  // A zero divisor bypasses iteration; the lanes saturate from the dividend sign alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      dvs_mag   <= '0;
      div0_job  <= 1'b0;
      div0      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) state <= dvs_zero ? S_FIX : S_RUN;
        end
        S_RUN: begin
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= S_FIX;
        end
        S_FIX: begin
          out_valid <= 1'b1;
          div0      <= div0_job;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) state <= dvs_zero ? S_FIX : S_RUN;
            else          state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (accept) begin
        dvs_mag  <= dvs_mag_in;
        div0_job <= dvs_zero;
        cnt      <= CW'(QB - 1);
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    div_iter_lane #(
      .W      (W),
      .FRAC   (FRAC),
      .SIGNED (SIGNED)
    ) u_lane (
      .clk         (clk),
      .reset_n     (reset_n),
      .load        (accept),
      .step        (state == S_RUN),
      .fix         (state == S_FIX),
      .div0        (div0_job),
      .dividend    (dividends[i]),
      .divisor_neg (dvs_neg_in),
      .divisor_mag (dvs_mag),
      .quotient    (quotients[i]),
      .ovf         (ovf[i])
    );
  end

endmodule

// File: tb/tb_array_div_seq.sv
// Directed and random jobs through array_div_seq, checked against a native-division model.
module tb_array_div_seq;

  localparam int N    = 6;
  localparam int W    = 36;
  localparam int FRAC = 16;
  localparam int QB   = W + FRAC;
  localparam longint QMAX = (longint'(1) <<< (W - 1)) - 1;
  localparam longint QMIN = -(longint'(1) <<< (W - 1));

  typedef struct {
    logic [N-1:0][W-1:0] q;
    logic                d0;
    logic [N-1:0]        ov;
    int                  lat;
  } exp_t;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                in_valid;
  logic                in_ready;
  logic [W-1:0]        divisor;
  logic [N-1:0][W-1:0] dividends;
  logic                out_valid;
  logic                out_ready;
  logic [N-1:0][W-1:0] quotients;
  logic                div0;
  logic [N-1:0]        ovf;

  exp_t sb[$];
  exp_t last_exp;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   acc_cyc = 0;

  array_div_seq #(.N(N), .W(W), .FRAC(FRAC), .SIGNED(1'b1)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .divisor   (divisor),
    .dividends (dividends),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotients (quotients),
    .div0      (div0),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0][W-1:0] mk(input logic [W-1:0] a0, a1, a2, a3, a4, a5);
    return {a5, a4, a3, a2, a1, a0};
  endfunction

  function automatic exp_t model(input logic [W-1:0] dvs, input logic [N-1:0][W-1:0] dvd);
    exp_t   e;
    longint a, b, r;
    b    = longint'(signed'(dvs));
    e.d0 = (b == 0);
    e.lat = (b == 0) ? 1 : QB + 1;
    e.ov = '0;
    for (int i = 0; i < N; i++) begin
      a = longint'(signed'(dvd[i]));
      if (b == 0) begin
        r = (a > 0) ? QMAX : ((a < 0) ? QMIN : 0);
      end else begin
        r = (a * (longint'(1) <<< FRAC)) / b;
        if (r > QMAX) begin
          r = QMAX;
          e.ov[i] = 1'b1;
        end else if (r < QMIN) begin
          r = QMIN;
          e.ov[i] = 1'b1;
        end
      end
      e.q[i] = r[W-1:0];
    end
    return e;
  endfunction

  task automatic applyStimulus(input logic [W-1:0] dvs, input logic [N-1:0][W-1:0] dvd);
    int g;
    sb.push_back(model(dvs, dvd));
    divisor   = dvs;
    dividends = dvd;
    in_valid  = 1'b1;
    g = 0;
    while (!in_ready && g < 200) begin
      tick();
      g++;
    end
    if (!in_ready) check("accept_timeout", {63'd0, in_ready}, 64'd1);
    tick();
    acc_cyc   = cyc;
    in_valid  = 1'b0;
    divisor   = W'({$urandom, $urandom});
    dividends = {N{W'({$urandom, $urandom})}};
  endtask

  task automatic checkOutput();
    int   g;
    exp_t e;
    g = 0;
    while (!out_valid && g < 500) begin
      tick();
      g++;
    end
    if (sb.size() == 0) begin
      check("scoreboard_empty", 64'd0, 64'd1);
      return;
    end
    e = sb.pop_front();
    last_exp = e;
    check("out_valid", {63'd0, out_valid}, 64'd1);
    check("latency", 64'(cyc - acc_cyc), 64'(e.lat));
    for (int i = 0; i < N; i++) check($sformatf("quotient%0d", i), 64'(quotients[i]), 64'(e.q[i]));
    check("div0", {63'd0, div0}, {63'd0, e.d0});
    check("ovf", 64'(ovf), 64'(e.ov));
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("out_valid_after_transfer", {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    logic [W-1:0] d;
    logic [N-1:0][W-1:0] v;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    divisor   = '0;
    dividends = '0;
    #2;
    check("reset_in_ready", {63'd0, in_ready}, 64'd0);
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_quotients", 64'(quotients[0]), 64'd0);
    check("reset_div0", {63'd0, div0}, 64'd0);
    check("reset_ovf", 64'(ovf), 64'd0);
    repeat (3) tick();
    reset_n = 1'b1;
    #1;
    check("idle_in_ready", {63'd0, in_ready}, 64'd1);

    $display("[TB] basic divide");
    applyStimulus(36'h0_0001_8000, mk(36'h0_0003_0000, 36'h0_0001_0000, 36'hF_FFFD_0000,
                                      36'h0_0000_0001, 36'h0_1234_5678, 36'h0));
    checkOutput();
    check("basic_const", 64'(quotients[0]), 64'h2_0000);
    drain();

    $display("[TB] signs");
    applyStimulus(36'h0_0004_0000, mk(36'hF_FFFF_0000, 36'h0_0001_0000, 36'h7_FFFF_FFFF,
                                      36'h8_0000_0000, 36'hF_FFFF_FFFF, 36'h0_0000_0003));
    checkOutput();
    check("neg_quarter", 64'(quotients[0]), 64'h0000_000F_FFFF_C000);
    drain();
    applyStimulus(36'hF_FFFF_0000, mk(36'hF_FFFF_0000, 36'h0_0002_0000, 36'h0_0000_0007,
                                      36'hF_FFF8_0000, 36'h0, 36'h0_0000_FFFF));
    checkOutput();
    check("neg_by_neg", 64'(quotients[0]), 64'h1_0000);
    drain();

    $display("[TB] divide by zero");
    applyStimulus(36'h0, mk(36'h0_0001_0000, 36'hF_FFFF_0000, 36'h0,
                            36'h8_0000_0000, 36'h0_0000_0001, 36'h7_FFFF_FFFF));
    checkOutput();
    check("div0_pos", 64'(quotients[0]), 64'h7_FFFF_FFFF);
    check("div0_neg", 64'(quotients[1]), 64'h8_0000_0000);
    drain();

    $display("[TB] overflow");
    applyStimulus(36'h0_0000_0001, mk(36'h7_FFFF_FFFF, 36'h8_0000_0000, 36'h0_0000_0100,
                                      36'hF_FFFF_FFFF, 36'h0, 36'h0_0000_7FFF));
    checkOutput();
    check("ovf_const", 64'(ovf), 64'h03);
    drain();

    $display("[TB] backpressure and back-to-back");
    applyStimulus(36'h0_0003_0000, mk(36'h0_0009_0000, 36'hF_FFF0_0000, 36'h0_0000_1234,
                                      36'h1_0000_0000, 36'h8_0000_0000, 36'h0_0000_0005));
    checkOutput();
    for (int k = 0; k < 10; k++) begin
      tick();
      check("hold_valid", {63'd0, out_valid}, 64'd1);
      check("hold_in_ready", {63'd0, in_ready}, 64'd0);
      check("hold_q0", 64'(quotients[0]), 64'(last_exp.q[0]));
      check("hold_q4", 64'(quotients[4]), 64'(last_exp.q[4]));
    end
    out_ready = 1'b1;
    applyStimulus(36'h0_0000_8000, mk(36'h0_0001_0000, 36'hF_FFFF_8000, 36'h0_0100_0000,
                                      36'h0, 36'h0_0000_0011, 36'hF_0000_0000));
    out_ready = 1'b0;
    check("b2b_valid_falls", {63'd0, out_valid}, 64'd0);
    checkOutput();
    drain();

    $display("[TB] reset mid-job");
    applyStimulus(36'h0_0000_0001, mk(36'h7_FFFF_FFFF, 36'h0_0000_0001, 36'h0_0000_0002,
                                      36'h0_0000_0003, 36'h0_0000_0004, 36'h0_0000_0005));
    repeat (20) tick();
    reset_n = 1'b0;
    #1;
    sb.delete();
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_quotients", 64'(quotients[2]), 64'd0);
    check("midrst_div0", {63'd0, div0}, 64'd0);
    check("midrst_ovf", 64'(ovf), 64'd0);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd0);
    #3;
    reset_n = 1'b1;
    #1;
    check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    applyStimulus(36'hF_FFFE_0000, mk(36'h0_0005_0000, 36'hF_FFFF_0000, 36'h0_0000_0001,
                                      36'h8_0000_0000, 36'h0_7000_0000, 36'h0));
    checkOutput();
    drain();

    $display("[TB] random jobs");
    for (int r = 0; r < 4; r++) begin
      d = W'({$urandom, $urandom}) >> $urandom_range(0, 34);
      if ($urandom_range(0, 1) == 1) d = ~d + 1'b1;
      if (d == '0) d = 36'd3;
      for (int i = 0; i < N; i++) begin
        v[i] = W'({$urandom, $urandom}) >> $urandom_range(0, 35);
        if ($urandom_range(0, 1) == 1) v[i] = ~v[i] + 1'b1;
      end
      applyStimulus(d, v);
      checkOutput();
      drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
